// File: rtl/lcd_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_tx_pkg                                                           |
// | Shared register offsets, queue entry type and sequencer states for   |
// | the LCD transmit queue.                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lcd_tx_pkg;

  localparam logic [4:0] OFF_CMD    = 5'h00;
  localparam logic [4:0] OFF_DATA   = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_COLOR  = 5'h0C;
  localparam logic [4:0] OFF_FILL   = 5'h10;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } tx_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL_WAIT = 2'd1,
    ST_FILL_HI   = 2'd2,
    ST_FILL_LO   = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_tx_queue_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo                                                            |
// | Single-clock FIFO with combinational head and occupancy count.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int  DEPTH = 16,
  parameter int  LVL_W = $clog2(DEPTH) + 1,
  parameter type T     = logic [7:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  T                 push_data_i,
  input  logic             pop_i,
  output T                 head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array: no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_tx_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_tx_queue                                                         |
// | Memory-mapped byte queue plus colour-fill sequencer feeding the LCD  |
// | SPI serializer through a registered valid/ready byte stream.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcd_tx_queue
  import lcd_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  output logic        ready_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_dc,
  input  logic        tx_ready
);

  // The output register holds the queue head until its handshake, so the
  // user-visible level counts that byte as still queued (src_fifo_q).
  tx_state_t        state_q, state_d;
  logic             tx_valid_q, tx_valid_d, tx_dc_q, tx_dc_d, src_fifo_q, src_fifo_d;
  logic [7:0]       tx_data_q, tx_data_d, pair_lo_q, pair_lo_d;
  logic [15:0]      color_q, count_q;
  logic [LVL_W-1:0] ahead_q, ahead_dec, level, fifo_level;
  logic             ovf_q, fill_err_q;
  logic [31:0]      read_value_q;
  logic             fifo_empty, fifo_full_unused;
  tx_entry_t        fifo_head, push_entry;
  logic [4:0]       offset;
  logic             wr_en, rd_en, hs, pop_user, free, full, empty, fill_busy;
  logic             push_req, push_ok, fill_req, fill_start, status_rd;
  logic             load_fifo, load_hi, load_lo;
  logic [31:0]      status_word;
  logic             unused_bits;

  assign offset      = address_in[4:0];
  assign wr_en       = sel_in && (|write_mask_in);
  assign rd_en       = sel_in && read_in;
  assign hs          = tx_valid_q && tx_ready;
  assign pop_user    = hs && src_fifo_q;
  assign free        = !tx_valid_q || tx_ready;
  assign level       = fifo_level + LVL_W'(src_fifo_q);
  assign full        = (level == LVL_W'(FIFO_DEPTH));
  assign empty       = (level == '0);
  assign fill_busy   = (state_q != ST_IDLE);
  assign push_req    = wr_en && ((offset == OFF_CMD) || (offset == OFF_DATA));
  assign push_ok     = push_req && (!full || pop_user);
  assign fill_req    = wr_en && (offset == OFF_FILL) && (write_value_in[15:0] != 16'd0);
  assign fill_start  = fill_req && !fill_busy;
  assign status_rd   = rd_en && (offset == OFF_STATUS);
  assign ahead_dec   = ahead_q - LVL_W'(pop_user);
  assign push_entry  = '{dc: (offset == OFF_DATA), data: write_value_in[7:0]};
  assign status_word = 32'({ovf_q, fill_err_q, fill_busy, full, empty, level});
  assign unused_bits = ^{address_in[31:5], write_value_in[31:16], fifo_full_unused};

  assign ready_out      = sel_in;
  assign read_value_out = read_value_q;
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;
  assign tx_dc          = tx_dc_q;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W),
    .T     (tx_entry_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_ok),
    .push_data_i (push_entry),
    .pop_i       (load_fifo),
    .head_o      (fifo_head),
    .full_o      (fifo_full_unused),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: the fill waits for pre-fill entries, then alternates hi/lo.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (fill_start) state_d = ST_FILL_WAIT;
      ST_FILL_WAIT: if (free && (ahead_dec == '0)) state_d = ST_FILL_HI;
      ST_FILL_HI:   if (hs) state_d = ST_FILL_LO;
      ST_FILL_LO:   if (hs) state_d = (count_q == 16'd1) ? ST_IDLE : ST_FILL_HI;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output side: pick what, if anything, the tx register loads this cycle.
  always_comb begin
    load_fifo = 1'b0;
    load_hi   = 1'b0;
    load_lo   = 1'b0;
    unique case (state_q)
      ST_IDLE: load_fifo = free && !fifo_empty;
      ST_FILL_WAIT: begin
        if (free) begin
          if (ahead_dec != '0) load_fifo = !fifo_empty;
          else                 load_hi   = 1'b1;
        end
      end
      ST_FILL_HI: load_lo = hs;
      ST_FILL_LO: begin
        if (hs) begin
          if (count_q == 16'd1) load_fifo = !fifo_empty;
          else                  load_hi   = 1'b1;
        end
      end
      default: ;
    endcase

    tx_valid_d = hs ? 1'b0 : tx_valid_q;
    src_fifo_d = hs ? 1'b0 : src_fifo_q;
    tx_data_d  = tx_data_q;
    tx_dc_d    = tx_dc_q;
    pair_lo_d  = pair_lo_q;
    if (load_fifo) begin
      tx_valid_d = 1'b1;
      src_fifo_d = 1'b1;
      tx_data_d  = fifo_head.data;
      tx_dc_d    = fifo_head.dc;
    end else if (load_hi) begin
      // Latch the low byte with the high byte so a pair never mixes colours.
      tx_valid_d = 1'b1;
      tx_data_d  = color_q[15:8];
      tx_dc_d    = 1'b1;
      pair_lo_d  = color_q[7:0];
    end else if (load_lo) begin
      tx_valid_d = 1'b1;
      tx_data_d  = pair_lo_q;
      tx_dc_d    = 1'b1;
    end
  end

  // Datapath and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      tx_dc_q      <= 1'b0;
      src_fifo_q   <= 1'b0;
      pair_lo_q    <= 8'd0;
      color_q      <= 16'd0;
      count_q      <= 16'd0;
      ahead_q      <= '0;
      ovf_q        <= 1'b0;
      fill_err_q   <= 1'b0;
      read_value_q <= 32'd0;
    end else begin
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      tx_dc_q      <= tx_dc_d;
      src_fifo_q   <= src_fifo_d;
      pair_lo_q    <= pair_lo_d;
      read_value_q <= status_rd ? status_word : 32'd0;
      if (wr_en && (offset == OFF_COLOR)) color_q <= write_value_in[15:0];
      if (fill_start)                     count_q <= write_value_in[15:0];
      else if (state_q == ST_FILL_LO && hs) count_q <= count_q - 16'd1;
      if (fill_start)                     ahead_q <= level - LVL_W'(pop_user);
      else if (state_q == ST_FILL_WAIT)   ahead_q <= ahead_dec;
      ovf_q      <= (push_req && !push_ok) || (ovf_q && !status_rd);
      fill_err_q <= (fill_req && fill_busy) || (fill_err_q && !status_rd);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_tx_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_tx_queue                                                      |
// | Scoreboard bench for the LCD transmit queue and fill sequencer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lcd_tx_queue;
  import lcd_tx_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_in = 32'd0;
  logic        sel_in = 1'b0;
  logic        read_in = 1'b0;
  logic [3:0]  write_mask_in = 4'd0;
  logic [31:0] write_value_in = 32'd0;
  logic [31:0] read_value_out;
  logic        ready_out;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_dc;
  logic        tx_ready = 1'b0;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          tx_count = 0;
  int          ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  logic [8:0]  sb[$];
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_val = 9'd0;

  lcd_tx_queue #(.FIFO_DEPTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_in        (read_in),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .read_value_out (read_value_out),
    .ready_out      (ready_out),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_dc          (tx_dc),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serializer-side ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares each handshake to the scoreboard and checks stall stability.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_stable", 32'({tx_valid, tx_dc, tx_data}), 32'({1'b1, prev_val}));
      if (tx_valid && tx_ready) begin
        tx_count++;
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("tx_byte", 32'({tx_dc, tx_data}), 32'(sb.pop_front()));
      end
      ready_check: assert (ready_out == sel_in);
      prev_stall = tx_valid && !tx_ready;
      prev_val   = {tx_dc, tx_data};
    end
  end

  task automatic expect_byte(input logic dc, input logic [7:0] d);
    sb.push_back({dc, d});
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] v);
    address_in = 32'(off); write_value_in = v; sel_in = 1'b1; write_mask_in = 4'hF;
    @(posedge clk); #1;
    sel_in = 1'b0; write_mask_in = 4'h0;
  endtask

  task automatic rd_status(output logic [31:0] v);
    address_in = 32'(OFF_STATUS); sel_in = 1'b1; read_in = 1'b1;
    @(posedge clk); #1;
    sel_in = 1'b0; read_in = 1'b0;
    v = read_value_out;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", 32'(sb.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    int          cnt0;
    int          n;
    logic        found;

    cycles(3);
    reset = 1'b0;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_word", 32'({tx_dc, tx_data}), 32'd0);
    check("rst_rdata", read_value_out, 32'd0);
    rd_status(st);
    check("rst_status", st, 32'h20);

    // Command then data byte, in order.
    ready_mode = 1; cycles(2);
    expect_byte(1'b0, 8'h2C); expect_byte(1'b1, 8'h55);
    wr(OFF_CMD, 32'h2C); wr(OFF_DATA, 32'h55);
    drain();
    rd_status(st);
    check("status_after_cmd", st, 32'h20);

    // Fill of 3 pixels.
    for (int i = 0; i < 3; i++) begin expect_byte(1'b1, 8'hF8); expect_byte(1'b1, 8'h00); end
    wr(OFF_COLOR, 32'hF800); wr(OFF_FILL, 32'd3);
    drain();
    rd_status(st);
    check("status_after_fill", st, 32'h20);

    // Commands around a fill keep their ordering.
    expect_byte(1'b0, 8'h2A);
    for (int i = 0; i < 2; i++) begin expect_byte(1'b1, 8'h12); expect_byte(1'b1, 8'h34); end
    expect_byte(1'b0, 8'h2B);
    wr(OFF_CMD, 32'h2A); wr(OFF_COLOR, 32'h1234); wr(OFF_FILL, 32'd2); wr(OFF_CMD, 32'h2B);
    drain();

    // Overflow: 17 pushes into a 16-entry queue with the serializer stalled.
    ready_mode = 0; cycles(2);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) expect_byte(1'b0, 8'(8'h40 + i));
      wr(OFF_CMD, 32'(8'h40 + i));
    end
    rd_status(st);
    check("status_full_ovf", st, 32'h250);
    rd_status(st);
    check("status_ovf_cleared", st, 32'h050);
    ready_mode = 1;
    drain();
    rd_status(st);
    check("status_after_ovf_drain", st, 32'h20);

    // Fill of 4 with random stalls, plus a rejected FILL mid-fill.
    ready_mode = 2; cycles(1);
    cnt0 = tx_count;
    for (int i = 0; i < 4; i++) begin expect_byte(1'b1, 8'hA5); expect_byte(1'b1, 8'hC3); end
    wr(OFF_COLOR, 32'hA5C3); wr(OFF_FILL, 32'd4); wr(OFF_FILL, 32'd5);
    rd_status(st);
    check("busy_and_fill_err", (st >> 7) & 32'h3, 32'h3);
    drain();
    check("fill4_byte_count", 32'(tx_count - cnt0), 32'd8);
    rd_status(st);
    check("status_after_fill4", st, 32'h20);

    // Reset while presenting the low byte of a long fill.
    ready_mode = 1; cycles(2);
    for (int i = 0; i < 100; i++) begin expect_byte(1'b1, 8'hAB); expect_byte(1'b1, 8'hCD); end
    wr(OFF_COLOR, 32'hABCD); wr(OFF_FILL, 32'd100);
    n = 0; found = 1'b0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      found = tx_valid && tx_dc && (tx_data == 8'hCD);
    end
    check("saw_fill_lo", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    cnt0 = tx_count;
    cycles(30);
    check("post_rst_no_bytes", 32'(tx_count - cnt0), 32'd0);
    check("post_rst_tx_valid", 32'(tx_valid), 32'd0);
    rd_status(st);
    check("post_rst_status", st, 32'h20);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
